// File: rtl/register_access_arbiter.sv
// Arbitrates the register file write port and rs1 address path between core writeback
// and a single outstanding debug read/write, forcing a one-cycle core stall after STARVE_LIMIT blocked cycles.
module register_access_arbiter #(
  parameter int REGISTER_COUNT = 32,
  parameter int WORD_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  localparam int ADDR_W        = $clog2(REGISTER_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_wr_valid,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [WORD_W-1:0] core_wr_data,
  output logic              core_stall,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_write,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [WORD_W-1:0] dbg_req_wdata,
  output logic              dbg_resp_valid,
  input  logic              dbg_resp_ready,
  output logic [WORD_W-1:0] dbg_resp_rdata,
  output logic              rf_wr_enable,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [WORD_W-1:0] rf_wr_data,
  output logic              rf_rs1_sel,
  output logic [ADDR_W-1:0] rf_rs1_addr,
  input  logic [WORD_W-1:0] rf_xs1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic                hold_write;
  logic [ADDR_W-1:0]   hold_addr;
  logic [WORD_W-1:0]   hold_wdata;
  logic [WORD_W-1:0]   resp_data;
  logic [3:0]          blk_cnt;
  logic                accept;
  logic                exec_go;

  // Response word: x0 always reads back as zero; writes echo the value written.
  function automatic logic [WORD_W-1:0] resp_value(input logic              is_write,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [WORD_W-1:0] wdata,
                                                   input logic [WORD_W-1:0] rdata);
    if (addr == '0)
      return '0;
    return is_write ? wdata : rdata;
  endfunction

  always_comb begin
    state_nxt      = state;
    dbg_req_ready  = 1'b0;
    dbg_resp_valid = 1'b0;
    accept         = 1'b0;
    exec_go        = 1'b0;
    case (state)
      IDLE: begin
        dbg_req_ready = 1'b1;
        if (dbg_req_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // Reset in this cycle must suppress the debug access entirely.
        if (!reset && (!core_wr_valid || blk_cnt == 4'(STARVE_LIMIT))) begin
          exec_go   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        dbg_resp_valid = 1'b1;
        if (dbg_resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_stall     = exec_go;
    rf_rs1_sel     = exec_go && !hold_write;
    rf_rs1_addr    = rf_rs1_sel ? hold_addr : '0;
    dbg_resp_rdata = resp_data;
    if (exec_go) begin
      rf_wr_enable = hold_write && (hold_addr != '0);
      rf_wr_addr   = hold_addr;
      rf_wr_data   = hold_wdata;
    end else begin
      rf_wr_enable = core_wr_valid && (core_wr_addr != '0);
      rf_wr_addr   = core_wr_addr;
      rf_wr_data   = core_wr_data;
    end
  end

  // Control state and response register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      blk_cnt   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        blk_cnt <= '0;
      else if (state == EXEC && !exec_go)
        blk_cnt <= blk_cnt + 4'd1;
      if (exec_go)
        resp_data <= resp_value(hold_write, hold_addr, hold_wdata, rf_xs1);
    end
  end

  // Request holding registers
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_write <= dbg_req_write;
      hold_addr  <= dbg_req_addr;
      hold_wdata <= dbg_req_wdata;
    end
  end

endmodule

// File: tb/tb_register_access_arbiter.sv
// Directed bench for register_access_arbiter with a behavioural register file and a response scoreboard.
module tb_register_access_arbiter;
  localparam int RC = 32;
  localparam int WW = 32;
  localparam int SL = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          preload;
  logic          core_wr_valid;
  logic [AW-1:0] core_wr_addr;
  logic [WW-1:0] core_wr_data;
  logic          core_stall;
  logic          dbg_req_valid;
  logic          dbg_req_ready;
  logic          dbg_req_write;
  logic [AW-1:0] dbg_req_addr;
  logic [WW-1:0] dbg_req_wdata;
  logic          dbg_resp_valid;
  logic          dbg_resp_ready;
  logic [WW-1:0] dbg_resp_rdata;
  logic          rf_wr_enable;
  logic [AW-1:0] rf_wr_addr;
  logic [WW-1:0] rf_wr_data;
  logic          rf_rs1_sel;
  logic [AW-1:0] rf_rs1_addr;
  logic [WW-1:0] rf_xs1;

  logic [WW-1:0] regs [RC];
  logic [WW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  register_access_arbiter #(.REGISTER_COUNT(RC), .WORD_W(WW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_stall(core_stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_write(dbg_req_write),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready), .dbg_resp_rdata(dbg_resp_rdata),
    .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rs1_sel(rf_rs1_sel), .rf_rs1_addr(rf_rs1_addr), .rf_xs1(rf_xs1)
  );

  always #5 clk = ~clk;

  // Register file model; x0 deliberately holds a nonzero value so the arbiter must force zero.
  always_ff @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < RC; i++) regs[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (rf_wr_enable) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_xs1 = rf_rs1_sel ? regs[rf_rs1_addr] : regs[3];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d,
                       input logic [WW-1:0] expv);
    dbg_req_valid = 1'b1;
    dbg_req_write = wr;
    dbg_req_addr  = a;
    dbg_req_wdata = d;
    #1;
    chk("req_ready_at_issue", 32'(dbg_req_ready), 32'd1);
    exp_q.push_back(expv);
    step();
    dbg_req_valid = 1'b0;
    #1;
  endtask

  task automatic pop_cmp(input string tag);
    logic [WW-1:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_rdata"}, dbg_resp_rdata, e);
  endtask

  task automatic expect_resp(input string tag);
    int i;
    i = 0;
    while (!dbg_resp_valid && i < 50) begin
      step();
      i++;
    end
    chk({tag, "_valid"}, 32'(dbg_resp_valid), 32'd1);
    pop_cmp(tag);
    dbg_resp_ready = 1'b1;
    step();
    chk({tag, "_done"}, 32'(dbg_resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    core_wr_valid = 1'b0; core_wr_addr = '0; core_wr_data = '0;
    dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    dbg_resp_ready = 1'b1;
    step(); step();
    preload = 1'b0;
    chk("rst_core_stall", 32'(core_stall), 32'd0);
    chk("rst_req_ready", 32'(dbg_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(dbg_resp_valid), 32'd0);
    chk("rst_resp_rdata", dbg_resp_rdata, 32'd0);
    chk("rst_rs1_sel", 32'(rf_rs1_sel), 32'd0);
    chk("rst_rs1_addr", 32'(rf_rs1_addr), 32'd0);
    reset = 1'b0;
    step();

    // Debug write x5 with idle core
    issue(1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("wr_x5_stall", 32'(core_stall), 32'd1);
    chk("wr_x5_we", 32'(rf_wr_enable), 32'd1);
    chk("wr_x5_addr", 32'(rf_wr_addr), 32'd5);
    chk("wr_x5_data", rf_wr_data, 32'hDEAD_BEEF);
    chk("wr_x5_req_ready", 32'(dbg_req_ready), 32'd0);
    step();
    chk("wr_x5_resp_t2", 32'(dbg_resp_valid), 32'd1);
    expect_resp("wr_x5");

    // Debug read x5 with idle core
    issue(1'b0, 5'd5, '0, 32'hDEAD_BEEF);
    chk("rd_x5_sel", 32'(rf_rs1_sel), 32'd1);
    chk("rd_x5_rs1_addr", 32'(rf_rs1_addr), 32'd5);
    chk("rd_x5_stall", 32'(core_stall), 32'd1);
    chk("rd_x5_we", 32'(rf_wr_enable), 32'd0);
    expect_resp("rd_x5");

    // Core writes every cycle: forced stall after SL blocked cycles
    core_wr_valid = 1'b1; core_wr_addr = 5'd7; core_wr_data = 32'h7777_7777;
    issue(1'b0, 5'd5, '0, 32'hDEAD_BEEF);
    for (int k = 1; k <= SL; k++) begin
      chk("starve_blocked_stall", 32'(core_stall), 32'd0);
      chk("starve_core_we", 32'(rf_wr_enable), 32'd1);
      chk("starve_core_addr", 32'(rf_wr_addr), 32'd7);
      step();
    end
    chk("starve_forced_stall", 32'(core_stall), 32'd1);
    chk("starve_rs1_sel", 32'(rf_rs1_sel), 32'd1);
    chk("starve_core_dropped", 32'(rf_wr_enable), 32'd0);
    step();
    chk("starve_resp_valid", 32'(dbg_resp_valid), 32'd1);
    chk("starve_core_in_resp", 32'(rf_wr_enable), 32'd1);
    core_wr_valid = 1'b0;
    #1;
    expect_resp("starve_rd");
    issue(1'b0, 5'd7, '0, 32'h7777_7777);
    expect_resp("rd_x7");

    // x0 from both sources
    core_wr_valid = 1'b1; core_wr_addr = 5'd0; core_wr_data = 32'hFFFF_FFFF;
    #1;
    chk("core_x0_we", 32'(rf_wr_enable), 32'd0);
    core_wr_valid = 1'b0;
    issue(1'b1, 5'd0, 32'h0000_1234, 32'd0);
    chk("wr_x0_stall", 32'(core_stall), 32'd1);
    chk("wr_x0_we", 32'(rf_wr_enable), 32'd0);
    expect_resp("wr_x0");
    issue(1'b0, 5'd0, '0, 32'd0);
    chk("rd_x0_sel", 32'(rf_rs1_sel), 32'd1);
    expect_resp("rd_x0");

    // Response backpressure with a second request waiting
    dbg_resp_ready = 1'b0;
    issue(1'b1, 5'd9, 32'h0BAD_F00D, 32'h0BAD_F00D);
    step();
    dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd5; dbg_req_wdata = '0;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid_hold", 32'(dbg_resp_valid), 32'd1);
      chk("bp_rdata_hold", dbg_resp_rdata, 32'h0BAD_F00D);
      chk("bp_req_blocked", 32'(dbg_req_ready), 32'd0);
      step();
    end
    dbg_resp_ready = 1'b1;
    #1;
    pop_cmp("bp_first");
    step();
    chk("bp_idle_ready", 32'(dbg_req_ready), 32'd1);
    chk("bp_idle_valid", 32'(dbg_resp_valid), 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    dbg_req_valid = 1'b0;
    #1;
    chk("bp_second_sel", 32'(rf_rs1_sel), 32'd1);
    expect_resp("bp_second");

    // Reset while blocked in EXEC
    core_wr_valid = 1'b1; core_wr_addr = 5'd7;
    issue(1'b1, 5'd11, 32'h1111_1111, 32'h1111_1111);
    chk("rst_mid_blocked", 32'(core_stall), 32'd0);
    step();
    chk("rst_mid_blocked2", 32'(core_stall), 32'd0);
    core_wr_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rst_mid_no_dbg_we", 32'(rf_wr_enable), 32'd0);
    chk("rst_mid_no_stall", 32'(core_stall), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_mid_idle", 32'(dbg_req_ready), 32'd1);
    chk("rst_mid_no_resp", 32'(dbg_resp_valid), 32'd0);
    chk("rst_mid_stall_low", 32'(core_stall), 32'd0);
    if (exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
    repeat (3) step();
    chk("rst_mid_still_no_resp", 32'(dbg_resp_valid), 32'd0);
    issue(1'b0, 5'd11, '0, 32'hA5A5_000B);
    expect_resp("rd_x11_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
